// File: rtl/qadd_rr_sched.sv
// Round-robin shared fixed-point adder with one registered, tagged output stage.
// Optional QADD_SAT_EN: saturate the sum on signed overflow instead of wrapping.
module qadd_rr_sched #(
    parameter int N    = 8,
    parameter int Q    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              res_ovf,
    output logic              busy
);

    if (Q >= N || (1 << IDW) < NREQ) begin : g_cfg_err
        $error("qadd_rr_sched: bad Q/IDW for given N/NREQ");
    end

    logic           valid_q, valid_d;
    logic [N-1:0]   data_q, data_d;
    logic [IDW-1:0] id_q, id_d;
    logic           ovf_q, ovf_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           slot_free;
    logic           accept;
    logic [N-1:0]   a_sel, b_sel, raw, sum;
    logic           ovf;

    // Scan ptr, ptr+1, ... modulo NREQ; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                a_sel = req_a[i*N +: N];
                b_sel = req_b[i*N +: N];
            end
        end
    end

    assign raw = a_sel + b_sel;
    assign ovf = (a_sel[N-1] == b_sel[N-1]) && (raw[N-1] != a_sel[N-1]);

`ifdef QADD_SAT_EN
    assign sum = !ovf ? raw :
                 a_sel[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
    assign sum = raw;
`endif

    assign slot_free = !valid_q || res_ready;
    assign accept    = slot_free && found && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = sum;
            id_d    = win;
            ovf_d   = ovf;
            ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        end else if (valid_q && res_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign res_valid = valid_q;
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_ovf   = ovf_q;
    assign busy      = valid_q || (|req_valid);

endmodule

// File: tb/tb_qadd_rr_sched.sv
// Directed + randomized bench for qadd_rr_sched
// against a behavioural reference model.
module tb_qadd_rr_sched;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ovf;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  bit         m_ovf;
  bit         last_acc;
  int         last_win;

  qadd_rr_sched #(
    .N(8), .Q(4), .NREQ(4), .IDW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_id(res_id),
    .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic bad(
    input string tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    failures++;
    $error("FAIL %s observed=%0h expected=%0h",
           tag, o, e);
  endtask

  function automatic void exp_sum(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] d,
    output bit o
  );
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    o  = (s > 127) || (s < -128);
`ifdef QADD_SAT_EN
    if (o) d = (sa >= 0) ? 8'h7F : 8'h80;
    else   d = 8'(s);
`else
    d = 8'(s);
`endif
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_valid  = 0;
    m_data   = 8'h00;
    m_id     = 0;
    m_ovf    = 0;
    last_acc = 0;
    last_win = -1;
  endtask

  task automatic cycle();
    int         win;
    bit         slot;
    logic [3:0] er;
    logic [7:0] d;
    bit         o;
    bit         eb;
    slot = !m_valid || res_ready;
    win  = -1;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (win < 0 && req_valid[j]) win = j;
    end
    er = (slot && win >= 0) ?
         4'(1 << win) : 4'b0000;
    eb = m_valid || (req_valid != 4'b0);
    #1;
    checks++;
    if (req_ready !== er)
      bad("req_ready", req_ready, er);
    checks++;
    if (busy !== eb)
      bad("busy", busy, eb);
    @(posedge clk);
    last_acc = slot && (win >= 0);
    last_win = win;
    if (last_acc) begin
      exp_sum(req_a[win*8 +: 8],
              req_b[win*8 +: 8], d, o);
      m_data  = d;
      m_ovf   = o;
      m_id    = win;
      m_valid = 1;
      m_ptr   = (win + 1) % NR;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    checks++;
    if (res_valid !== m_valid)
      bad("res_valid", res_valid, m_valid);
    checks++;
    if (res_data !== m_data)
      bad("res_data", res_data, m_data);
    checks++;
    if (res_id !== 2'(m_id))
      bad("res_id", res_id, m_id);
    checks++;
    if (res_ovf !== m_ovf)
      bad("res_ovf", res_ovf, m_ovf);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0)
      bad("rst_res_valid", res_valid, 0);
    checks++;
    if (res_data !== 8'h00)
      bad("rst_res_data", res_data, 0);
    checks++;
    if (res_id !== 2'd0)
      bad("rst_res_id", res_id, 0);
    checks++;
    if (res_ovf !== 1'b0)
      bad("rst_res_ovf", res_ovf, 0);
    checks++;
    if (req_ready !== 4'b0000)
      bad("rst_req_ready", req_ready, 0);
    model_reset();
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit pend;
    bit nv;
    model_reset();

    do_reset();
    req_valid  = 4'b0001;
    req_a[7:0] = 8'h18;
    req_b[7:0] = 8'h08;
    res_ready  = 1'b1;
    cycle();
    checks++;
    if (res_data !== 8'h20)
      bad("single_data", res_data, 8'h20);
    checks++;
    if (res_id !== 2'd0)
      bad("single_id", res_id, 0);

    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*8 +: 8] = 8'(i);
      req_b[i*8 +: 8] = 8'h01;
    end
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (res_id !== 2'(k % NR))
        bad("rr_id", res_id, k % NR);
      checks++;
      if (res_data !== 8'((k % NR) + 1))
        bad("rr_data", res_data,
            (k % NR) + 1);
    end

    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (res_id !== 2'd0)
        bad("bp_stable_id", res_id, 0);
    end
    res_ready = 1'b1;
    cycle();
    checks++;
    if (res_id !== 2'd1)
      bad("bp_next_id", res_id, 1);
    checks++;
    if (res_valid !== 1'b1)
      bad("bp_no_bubble", res_valid, 1);

    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b1001;
    cycle();
    checks++;
    if (res_id !== 2'd3)
      bad("skip_grant3", res_id, 3);
    req_valid = 4'b0000;
    cycle();
    req_valid = 4'b1001;
    cycle();
    checks++;
    if (res_id !== 2'd0)
      bad("skip_grant0", res_id, 0);

    req_valid  = 4'b0001;
    req_a[7:0] = 8'h70;
    req_b[7:0] = 8'h20;
    cycle();
    checks++;
    if (res_ovf !== 1'b1)
      bad("ovf_pos_flag", res_ovf, 1);
`ifdef QADD_SAT_EN
    checks++;
    if (res_data !== 8'h7F)
      bad("ovf_pos_data", res_data, 8'h7F);
`else
    checks++;
    if (res_data !== 8'h90)
      bad("ovf_pos_data", res_data, 8'h90);
`endif
    req_a[7:0] = 8'h80;
    req_b[7:0] = 8'hF0;
    cycle();
    checks++;
    if (res_ovf !== 1'b1)
      bad("ovf_neg_flag", res_ovf, 1);
`ifdef QADD_SAT_EN
    checks++;
    if (res_data !== 8'h80)
      bad("ovf_neg_data", res_data, 8'h80);
`else
    checks++;
    if (res_data !== 8'h70)
      bad("ovf_neg_data", res_data, 8'h70);
`endif

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        pend = req_valid[i] &&
               !(last_acc && last_win == i);
        nv   = 1'($urandom_range(0, 1));
        if (!pend || !nv) begin
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
        end
        req_valid[i] = nv;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    req_a     = 32'h0403_0201;
    req_b     = 32'h0101_0101;
    cycle();
    res_ready = 1'b0;
    req_valid = 4'b0101;
    cycle();
    checks++;
    if (res_valid !== 1'b1)
      bad("mid_pending", res_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0)
      bad("mid_rst_valid", res_valid, 0);
    checks++;
    if (req_ready !== 4'b0000)
      bad("mid_rst_ready", req_ready, 0);
    model_reset();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    cycle();
    checks++;
    if (res_id !== 2'd0)
      bad("mid_first_lane0", res_id, 0);
    cycle();
    checks++;
    if (res_id !== 2'd2)
      bad("mid_then_lane2", res_id, 2);
    checks++;
    if (res_data !== 8'h04)
      bad("mid_lane2_data", res_data, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/qadd_rr_sched.md
Name: qadd_rr_sched

Overview:
- Time-shares one fixed-point adder datapath (c = a + b, two's complement, Q fractional bits) between NREQ requesters, e.g. partial-sum lanes of a CNN tile.
- Round-robin arbitration with per-requester valid/ready.
- One registered output stage with valid/ready backpressure, tagged with the winning requester ID.
- Sits between the PE partial-sum producers and the accumulator/writeback path.

Parameters:
- N, 8, total operand/result width (1 sign bit + integer bits + Q fractional bits).
- Q, 4, fractional bits; informational only, adder arithmetic independent of Q.
- NREQ, 4, number of requesters, >= 2.
- IDW, 2, requester ID width, must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: pair i accepted this cycle; one-hot or zero.
- req_a  in  NREQ*N  operand a; requester i at bits [i*N +: N].
- req_b  in  NREQ*N  operand b; same packing.
- res_valid  out  1  result register holds valid data.
- res_ready  in  1  downstream accepts result.
- res_data  out  N  registered sum.
- res_id  out  IDW  index of requester that produced res_data.
- res_ovf  out  1  signed overflow occurred on this sum.
- busy  out  1  res_valid OR any req_valid.

Behaviour:
- Reset (async, rst_n low): res_valid=0, res_data=0, res_id=0, res_ovf=0, rr pointer=0. req_ready is combinational and is 0 while in reset.
- slot_free = !res_valid | res_ready.
- Arbitration: winner = first i with req_valid[i], scanning ptr, ptr+1, ..., wrapping mod NREQ.
- req_ready[winner] = slot_free. All other req_ready bits are 0.
- Accept = slot_free & any req_valid.
- On accept, at the clock edge:
  - res_data <= sum; res_id <= winner; res_ovf <= ovf; res_valid <= 1.
  - ptr <= (winner+1) mod NREQ.
- No accept but res_valid & res_ready: res_valid <= 0. res_data, res_id and res_ovf hold their last values.
- Latency: accepted pair appears on res_* the next cycle.
- Throughput: one result per cycle while res_ready stays high (accept and drain in the same cycle).
- Backpressure: res_valid & !res_ready gives:
  - res_* held stable;
  - all req_ready = 0;
  - ptr frozen.
- Requesters must hold req_a/req_b stable while req_valid is high and not accepted. Dropping req_valid before acceptance is allowed and loses nothing.
- ptr advances only on accept. An idle cycle does not move it.
- Sum: raw = a + b, modulo 2^N (N-bit wrap).
- ovf = (a[N-1]==b[N-1]) & (raw[N-1]!=a[N-1]).
- Reset asserted mid-stream: the pending result is discarded, no handshake completes, and ptr returns to 0.
- NREQ not a power of two: ptr wraps at NREQ-1 -> 0. IDs >= NREQ are never produced.
- A single requester that is continuously valid is granted every cycle. With multiple valid requesters, any one waits at most NREQ-1 accepts.

Optional Feature:
- Macro: QADD_SAT_EN.
- Defined: on ovf, res_data = most positive value (0 followed by ones, 0x7F for N=8) when a is non-negative, most negative value (1 followed by zeros, 0x80) when a is negative. res_ovf is still reported.
- Undefined: res_data = raw (wrapping), identical to the plain adder. res_ovf is still reported.

Test Plan:
- Reset/single op: rst_n low -> all outputs 0. Release; req_valid=0001, a0=0x18 (1.5), b0=0x08 (0.5), res_ready=1 -> req_ready=0001; next cycle res_valid=1, res_data=0x20, res_id=0, res_ovf=0.
- Round-robin: req_valid=1111 held, res_ready=1, each lane ai=i, bi=1 -> res_id sequence 0,1,2,3,0; res_data 1,2,3,4,1; one result per cycle.
- Backpressure: result pending, res_ready=0 for 3 cycles -> res_* stable, req_ready=0000, ptr frozen. res_ready=1 -> drain and new accept in the same cycle, no bubble.
- Fairness/skip: ptr=1, req_valid=1001 -> grant 3, then ptr=0 -> grant 0. Idle cycles between grants do not change order.
- Overflow: a=0x70, b=0x20 -> res_ovf=1. res_data=0x90 without QADD_SAT_EN, 0x7F with it. a=0x80, b=0xF0 -> res_ovf=1, res_data 0x70 / 0x80 respectively.
- Reset mid-stream: res_valid=1 and lane 2 waiting; pulse rst_n low asynchronously (between clock edges) -> res_valid drops immediately, ptr=0. After release, lane 0 is granted before lane 2.
